// File: rtl/fb_text_pkg.sv
// Shared types and constants for the frame-buffer text writer.
package fb_text_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_MERGE,
      S_WRITE,
      S_CLEAR
   } state_e;

   localparam logic [7:0] CH_NL       = 8'h0A;
   localparam logic [7:0] CH_CR       = 8'h0D;
   localparam logic [7:0] CH_BS       = 8'h08;
   localparam logic [7:0] CH_PRINT_LO = 8'h20;
   localparam logic [7:0] CH_PRINT_HI = 8'h7E;

   localparam int unsigned DEF_ADDR_WIDTH = 16;
   localparam logic [15:0] DEF_FB_BASE    = 16'h3000;
   localparam int unsigned DEF_ROW_STRIDE = 80;
   localparam int unsigned DEF_COLS       = 80;
   localparam int unsigned DEF_ROWS       = 60;
   localparam logic [7:0]  DEF_BLANK      = 8'h20;

   function automatic logic is_printable(input logic [7:0] c);
      return (c >= CH_PRINT_LO) && (c <= CH_PRINT_HI);
   endfunction

endpackage

// File: rtl/fb_cell_addr.sv
// Maps a glyph cell (row, col) to its frame-buffer word address and byte lane.
module fb_cell_addr
   import fb_text_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0]  FB_BASE    = DEF_FB_BASE,
   parameter int unsigned            ROW_STRIDE = DEF_ROW_STRIDE
) (
   input  logic [5:0]            row_i,
   input  logic [6:0]            col_i,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic                  sel_lo_o
);

   // Two glyphs share a word; odd columns live in the low byte.
   always_comb begin
      addr_o   = FB_BASE
               + ADDR_WIDTH'(ROW_STRIDE) * ADDR_WIDTH'(row_i)
               + ADDR_WIDTH'(col_i[6:1]);
      sel_lo_o = col_i[0];
   end

endmodule

// File: rtl/fb_text_writer.sv
// Text-console writer: cursor tracking plus read-modify-write of glyph cells
// on the frame-buffer write port, with control codes and full-screen clear.
module fb_text_writer
   import fb_text_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0]  FB_BASE    = DEF_FB_BASE,
   parameter int unsigned            ROW_STRIDE = DEF_ROW_STRIDE,
   parameter int unsigned            COLS       = DEF_COLS,
   parameter int unsigned            ROWS       = DEF_ROWS,
   parameter logic [7:0]             BLANK      = DEF_BLANK
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            char_in,
   input  logic                  char_valid,
   output logic                  char_ready,
   input  logic                  clear_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [15:0]           mem_wdata,
   output logic                  mem_we,
   input  logic [15:0]           mem_rdata,
   output logic [6:0]            cursor_col,
   output logic [5:0]            cursor_row,
   output logic                  busy
);

   localparam logic [6:0] LAST_COL  = 7'(COLS - 1);
   localparam logic [6:0] LAST_PAIR = 7'(COLS - 2);
   localparam logic [5:0] LAST_ROW  = 6'(ROWS - 1);

   state_e                  state_q;
   logic [6:0]              col_q;
   logic [5:0]              row_q;
   logic [7:0]              char_q;
   logic                    sel_lo_q;
   logic                    bs_q;
   logic [5:0]              clr_row_q;
   logic [6:0]              clr_col_q;
   logic                    mem_we_q;
   logic [ADDR_WIDTH-1:0]   mem_addr_q;
   logic [15:0]             mem_wdata_q;

   logic [5:0]              row_inc_d;
   logic [6:0]              col_adv_d;
   logic [5:0]              row_adv_d;
   logic [5:0]              clr_row_d;
   logic [6:0]              clr_col_d;
   logic                    clr_last;
   logic [5:0]              a_row;
   logic [6:0]              a_col;
   logic [ADDR_WIDTH-1:0]   cell_addr;
   logic                    cell_sel_lo;

   // Cursor/walker successor values and the shared address-unit input mux.
   always_comb begin
      row_inc_d = (row_q == LAST_ROW) ? '0 : row_q + 6'd1;
      if (col_q == LAST_COL) begin
         col_adv_d = '0;
         row_adv_d = row_inc_d;
      end else begin
         col_adv_d = col_q + 7'd1;
         row_adv_d = row_q;
      end
      clr_last = (clr_row_q == LAST_ROW) && (clr_col_q == LAST_PAIR);
      if (clr_col_q == LAST_PAIR) begin
         clr_col_d = '0;
         clr_row_d = clr_row_q + 6'd1;
      end else begin
         clr_col_d = clr_col_q + 7'd2;
         clr_row_d = clr_row_q;
      end
      a_row = row_q;
      a_col = col_q;
      if (state_q == S_CLEAR) begin
         a_row = clr_row_d;
         a_col = clr_col_d;
      end else if (char_in == CH_BS) begin
         a_col = col_q - 7'd1;
      end
   end

   fb_cell_addr #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .FB_BASE    (FB_BASE),
      .ROW_STRIDE (ROW_STRIDE)
   ) u_cell_addr (
      .row_i    (a_row),
      .col_i    (a_col),
      .addr_o   (cell_addr),
      .sel_lo_o (cell_sel_lo)
   );

   // Main controller: char decode, RMW sequencing, clear walker, registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         col_q       <= '0;
         row_q       <= '0;
         char_q      <= '0;
         sel_lo_q    <= 1'b0;
         bs_q        <= 1'b0;
         clr_row_q   <= '0;
         clr_col_q   <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= FB_BASE;
         mem_wdata_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (clear_req) begin
                  // First blank word is presented on entry so CLEAR writes every cycle.
                  mem_addr_q  <= FB_BASE;
                  mem_wdata_q <= {BLANK, BLANK};
                  mem_we_q    <= 1'b1;
                  clr_row_q   <= '0;
                  clr_col_q   <= '0;
                  state_q     <= S_CLEAR;
               end else if (char_valid) begin
                  if (is_printable(char_in)) begin
                     mem_addr_q <= cell_addr;
                     sel_lo_q   <= cell_sel_lo;
                     char_q     <= char_in;
                     bs_q       <= 1'b0;
                     state_q    <= S_READ;
                  end else if (char_in == CH_NL) begin
                     col_q <= '0;
                     row_q <= row_inc_d;
                  end else if (char_in == CH_CR) begin
                     col_q <= '0;
                  end else if (char_in == CH_BS && col_q != '0) begin
                     col_q      <= col_q - 7'd1;
                     mem_addr_q <= cell_addr;
                     sel_lo_q   <= cell_sel_lo;
                     char_q     <= BLANK;
                     bs_q       <= 1'b1;
                     state_q    <= S_READ;
                  end
               end
            end
            S_READ: begin
               mem_we_q <= 1'b0;
               state_q  <= S_MERGE;
            end
            S_MERGE: begin
               mem_wdata_q <= sel_lo_q ? {mem_rdata[15:8], char_q}
                                       : {char_q, mem_rdata[7:0]};
               mem_we_q    <= 1'b1;
               state_q     <= S_WRITE;
            end
            S_WRITE: begin
               mem_we_q <= 1'b0;
               if (!bs_q) begin
                  col_q <= col_adv_d;
                  row_q <= row_adv_d;
               end
               state_q <= S_IDLE;
            end
            S_CLEAR: begin
               if (clr_last) begin
                  mem_we_q <= 1'b0;
                  col_q    <= '0;
                  row_q    <= '0;
                  state_q  <= S_IDLE;
               end else begin
                  clr_row_q  <= clr_row_d;
                  clr_col_q  <= clr_col_d;
                  mem_addr_q <= cell_addr;
               end
            end
            default: begin
               mem_we_q <= 1'b0;
               state_q  <= S_IDLE;
            end
         endcase
      end
   end

   assign char_ready = (state_q == S_IDLE) && !clear_req;
   assign busy       = (state_q != S_IDLE);
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_we     = mem_we_q;
   assign cursor_col = col_q;
   assign cursor_row = row_q;

endmodule

// File: tb/tb_fb_text_writer.sv
// Scoreboard bench for fb_text_writer: stimulus pushes expected writes, a
// monitor pops and compares them whenever the DUT strobes mem_we.
module tb_fb_text_writer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  char_in = '0;
   logic        char_valid = 1'b0;
   logic        char_ready;
   logic        clear_req = 1'b0;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic [15:0] mem_rdata;
   logic [6:0]  cursor_col;
   logic [5:0]  cursor_row;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;

   logic [15:0] ram [0:65535];
   logic [15:0] exp_mem [0:65535];
   logic        ram_init = 1'b0;
   logic [31:0] expq [$];
   logic [31:0] mon_e;
   int          exp_row = 0;
   int          exp_col = 0;

   always #5 clk = ~clk;

   fb_text_writer #(
      .ADDR_WIDTH (16),
      .FB_BASE    (16'h3000),
      .ROW_STRIDE (80),
      .COLS       (80),
      .ROWS       (60),
      .BLANK      (8'h20)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .char_in    (char_in),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .clear_req  (clear_req),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .busy       (busy)
   );

   // Synchronous RAM, one-cycle read latency; background is blanks with a
   // sentinel in an unused stride word.
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 65536; i++) ram[i] <= 16'h2020;
         ram[16'h3028] <= 16'hBEEF;
      end else if (mem_we === 1'b1) begin
         ram[mem_addr] <= mem_wdata;
      end
      mem_rdata <= ram[mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the head of the expected queue.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (expq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
         end else begin
            mon_e = expq.pop_front();
            chk("write_addr", {16'h0, mem_addr}, {16'h0, mon_e[31:16]});
            chk("write_data", {16'h0, mem_wdata}, {16'h0, mon_e[15:0]});
         end
      end
   end

   function automatic logic [15:0] cell_word(input int r, input int c);
      return 16'h3000 + 16'(r * 80) + 16'(c / 2);
   endfunction

   // Reference behaviour: expected writes and cursor movement for one char.
   task automatic model_char(input logic [7:0] c);
      logic [15:0] a;
      logic [15:0] w;
      if (c >= 8'h20 && c <= 8'h7E) begin
         a = cell_word(exp_row, exp_col);
         w = exp_mem[a];
         if (exp_col % 2 == 0) w[15:8] = c; else w[7:0] = c;
         exp_mem[a] = w;
         expq.push_back({a, w});
         if (exp_col == 79) begin
            exp_col = 0;
            exp_row = (exp_row == 59) ? 0 : exp_row + 1;
         end else begin
            exp_col++;
         end
      end else if (c == 8'h0A) begin
         exp_col = 0;
         exp_row = (exp_row == 59) ? 0 : exp_row + 1;
      end else if (c == 8'h0D) begin
         exp_col = 0;
      end else if (c == 8'h08 && exp_col != 0) begin
         exp_col--;
         a = cell_word(exp_row, exp_col);
         w = exp_mem[a];
         if (exp_col % 2 == 0) w[15:8] = 8'h20; else w[7:0] = 8'h20;
         exp_mem[a] = w;
         expq.push_back({a, w});
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (char_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("ready_timeout", {31'h0, n < 50}, 32'h1);
   endtask

   task automatic send_char(input logic [7:0] c);
      wait_ready();
      model_char(c);
      char_in    = c;
      char_valid = 1'b1;
      @(posedge clk);
      #1 char_valid = 1'b0;
      wait_ready();
   endtask

   task automatic chk_cursor(input string name, input int r, input int c);
      chk({name, "_row"}, {26'h0, cursor_row}, r);
      chk({name, "_col"}, {25'h0, cursor_col}, c);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int hi;
      int busy_cyc;
      for (int i = 0; i < 65536; i++) exp_mem[i] = 16'h2020;
      exp_mem[16'h3028] = 16'hBEEF;
      ram_init = 1'b1;
      @(posedge clk);
      #1 ram_init = 1'b0;
      @(posedge clk);
      @(negedge clk);
      // Reset values
      chk("rst_we", {31'h0, mem_we}, 32'h0);
      chk("rst_addr", {16'h0, mem_addr}, 32'h3000);
      chk("rst_wdata", {16'h0, mem_wdata}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk_cursor("rst", 0, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ready", {31'h0, char_ready}, 32'h1);

      // 'A' with cycle-accurate timing checks
      model_char(8'h41);
      char_in = 8'h41; char_valid = 1'b1;
      @(posedge clk);
      #1 char_valid = 1'b0;
      @(negedge clk); chk("A_we_t1", {31'h0, mem_we}, 32'h0);
      chk("A_read_addr", {16'h0, mem_addr}, 32'h3000);
      @(negedge clk); chk("A_we_t2", {31'h0, mem_we}, 32'h0);
      @(negedge clk); chk("A_we_t3", {31'h0, mem_we}, 32'h1);
      chk("A_ready_t3", {31'h0, char_ready}, 32'h0);
      @(negedge clk); chk("A_ready_t4", {31'h0, char_ready}, 32'h1);
      chk("A_we_t4", {31'h0, mem_we}, 32'h0);
      chk("A_ram", {16'h0, ram[16'h3000]}, 32'h4120);
      chk_cursor("A", 0, 1);

      send_char(8'h42);
      chk("B_ram", {16'h0, ram[16'h3000]}, 32'h4142);
      chk_cursor("B", 0, 2);
      send_char(8'h0A);
      send_char(8'h0D);
      send_char(8'h01);
      chk_cursor("ctrl", 1, 0);

      // Walk to the last cell and wrap
      for (int i = 0; i < 58; i++) send_char(8'h0A);
      for (int i = 0; i < 79; i++) send_char(8'h78);
      chk_cursor("pre_Z", 59, 79);
      send_char(8'h5A);
      chk("Z_ram", {16'h0, ram[16'h4297]}, 32'h785A);
      chk_cursor("Z_wrap", 0, 0);

      // Backspace
      send_char(8'h43);
      send_char(8'h44);
      send_char(8'h45);
      chk("E_ram", {16'h0, ram[16'h3001]}, 32'h4520);
      chk_cursor("CDE", 0, 3);
      send_char(8'h08);
      chk_cursor("bs", 0, 2);
      chk("bs_ram", {16'h0, ram[16'h3001]}, 32'h2020);
      send_char(8'h0D);
      send_char(8'h08);
      chk_cursor("bs_col0", 0, 0);
      chk("bs_col0_busy", {31'h0, busy}, 32'h0);

      // Clear with a simultaneous char
      send_char(8'h4B);
      for (int r = 0; r < 60; r++)
         for (int w = 0; w < 40; w++) begin
            expq.push_back({16'h3000 + 16'(r * 80) + 16'(w), 16'h2020});
            exp_mem[16'h3000 + 16'(r * 80) + 16'(w)] = 16'h2020;
         end
      exp_row = 0; exp_col = 0;
      clear_req = 1'b1; char_valid = 1'b1; char_in = 8'h51;
      #1 chk("clr_ready_low", {31'h0, char_ready}, 32'h0);
      @(posedge clk);
      #1 clear_req = 1'b0; char_valid = 1'b0;
      hi = 0; busy_cyc = 0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (busy !== 1'b1) break;
         busy_cyc++;
         if (mem_we === 1'b1) hi++;
      end
      chk("clr_writes", hi, 2400);
      chk("clr_busy_cycles", busy_cyc, 2400);
      chk("clr_we_end", {31'h0, mem_we}, 32'h0);
      chk("clr_first", {16'h0, ram[16'h3000]}, 32'h2020);
      chk("clr_last", {16'h0, ram[16'h4297]}, 32'h2020);
      chk("clr_stride_untouched", {16'h0, ram[16'h3028]}, 32'hBEEF);
      chk_cursor("clr", 0, 0);
      chk("clr_ready", {31'h0, char_ready}, 32'h1);

      // Reset during MERGE
      send_char(8'h0A);
      chk_cursor("pre_rst", 1, 0);
      char_in = 8'h4D; char_valid = 1'b1;
      @(posedge clk);
      #1 char_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("merge_busy", {31'h0, busy}, 32'h1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mrst_we", {31'h0, mem_we}, 32'h0);
      chk("mrst_busy", {31'h0, busy}, 32'h0);
      chk_cursor("mrst", 0, 0);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("mrst_ready", {31'h0, char_ready}, 32'h1);
      exp_row = 0; exp_col = 0;
      repeat (6) @(negedge clk);
      chk("queue_empty", expq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
